// File: rtl/config_pkg.sv
// Shared types and constants for the configuration chain loader.
package config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/config_crc16.sv
// Bit-serial CRC-16-CCITT (MSB-first) over the bits driven onto the chain.
module config_crc16
  import config_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ data_bit;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Serialises handshaked bitstream words MSB-first onto the tile configuration chain.
// Optional CRC-16 of the shifted bits is enabled by defining CONFIG_LOADER_CRC_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no load in progress, waiting for start
// ST_LOAD  | waiting for the next word, chain stalled (enable low)
// ST_SHIFT | driving one bit per cycle with config_enable high
// ST_DONE  | CHAIN_LENGTH bits shifted, holding until start or abort
module config_chain_loader
  import config_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 20,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_enable,
  output logic                  config_data,
  output logic                  busy,
  output logic                  done
`ifdef CONFIG_LOADER_CRC_EN
  ,
  output logic [15:0]           crc
`endif
);

  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  loader_state_t         state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [IDX_W-1:0]      bit_idx;
  logic                  last_word_bit;
  logic                  last_chain_bit;

  assign cnt_next       = bit_cnt + CNT_WIDTH'(1);
  assign last_word_bit  = (bit_idx == IDX_W'(WORD_WIDTH - 1));
  assign last_chain_bit = (cnt_next == CNT_WIDTH'(CHAIN_LENGTH));

  // Ready on the last bit of a word lets the next word follow with no enable gap.
  assign word_ready    = (state == ST_LOAD) ||
                         ((state == ST_SHIFT) && last_word_bit && !last_chain_bit);
  assign config_enable = (state == ST_SHIFT);
  assign config_data   = shreg[WORD_WIDTH-1];
  assign busy          = (state == ST_LOAD) || (state == ST_SHIFT);
  assign done          = (state == ST_DONE);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (abort) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_LOAD;
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            shreg   <= word_data;
            bit_idx <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= cnt_next;
          shreg   <= {shreg[WORD_WIDTH-2:0], 1'b0};
          if (last_chain_bit) begin
            // Leftover low-order bits of the final word are dropped here.
            state <= ST_DONE;
          end else if (last_word_bit) begin
            bit_idx <= '0;
            if (word_valid) begin
              shreg <= word_data;
            end else begin
              state <= ST_LOAD;
            end
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CONFIG_LOADER_CRC_EN
  logic start_go;

  assign start_go = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));

  config_crc16 u_crc16 (
    .clock    (clock),
    .nreset   (nreset),
    .clear    (start_go),
    .enable   (config_enable),
    .data_bit (config_data),
    .crc      (crc)
  );
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader: bitstream model, chain model, directed loads.
module tb_config_chain_loader;

  localparam int WW = 8;
  localparam int CL = 20;

  logic          clock = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [WW-1:0] word_data = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          config_enable;
  logic          config_data;
  logic          busy;
  logic          done;
`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0]   crc;
`endif

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CNT_WIDTH(16)) dut (
    .clock         (clock),
    .nreset        (nreset),
    .start         (start),
    .abort         (abort),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .config_enable (config_enable),
    .config_data   (config_data),
    .busy          (busy),
    .done          (done)
`ifdef CONFIG_LOADER_CRC_EN
    ,
    .crc           (crc)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WW-1:0] words [0:2] = '{8'hA5, 8'h3C, 8'hF0};
  logic          exp_bits [0:CL-1];
  int            exp_idx = 0;
  logic [CL-1:0] chain = '0;
  bit            check_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef CONFIG_LOADER_CRC_EN
  function automatic logic [15:0] crc_of(input logic [31:0] v, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      if (c[15] ^ v[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Tile chain: each enabled bit enters at the near end, so bit 0 of the stream ends at the MSB.
  always @(posedge clock) begin
    if (config_enable) chain <= {chain[CL-2:0], config_data};
  end

  // Per-cycle compare of everything the chain sees against the expected bitstream.
  always @(negedge clock) begin
    if (check_on) begin
      if (config_enable) begin
        if (exp_idx >= CL) check("bit_overrun", 32'(exp_idx), 32'(CL - 1));
        else               check("serial_bit", {31'b0, config_data}, {31'b0, exp_bits[exp_idx]});
        exp_idx++;
        check("enable_implies_busy", {31'b0, busy}, 32'd1);
      end
      if (done) begin
        check("done_ready_low", {31'b0, word_ready}, 32'd0);
        check("done_enable_low", {31'b0, config_enable}, 32'd0);
        check("done_busy_low", {31'b0, busy}, 32'd0);
      end
      if (!nreset || (start && !abort && !busy)) exp_idx = 0;
    end
  end

  // Drives one load from the word table; entered and left aligned as documented by the callers.
  task automatic do_load(input int stall_idx, input int stall_len, input int abort_at,
                         input int busy_start_at, input int rst_at,
                         output int en_cnt, output int gap_cnt, output bit saw_done);
    int  widx  = 0;
    int  stall = 0;
    bit  acc;
    en_cnt   = 0;
    gap_cnt  = 0;
    saw_done = 1'b0;
    start      = 1'b1;
    word_valid = 1'b1;
    word_data  = words[0];
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clock);
      acc = word_valid && word_ready;
      if (config_enable) en_cnt++;
      else if (en_cnt > 0 && busy) gap_cnt++;
      if (done && cyc > 0) begin
        saw_done = 1'b1;
        break;
      end
      if (!busy && cyc > 0) break;
      @(posedge clock);
      #1;
      start = (en_cnt == busy_start_at);
      abort = (en_cnt == abort_at);
      if (en_cnt == rst_at) nreset = 1'b0;
      if (acc) begin
        widx++;
        if (widx == stall_idx) stall = stall_len;
      end
      word_valid = (widx < 3) && (stall == 0);
      word_data  = (widx < 3) ? words[widx] : '0;
      if (stall > 0) stall--;
    end
    start      = 1'b0;
    abort      = 1'b0;
    word_valid = 1'b0;
  endtask

  int          en_cnt, gap_cnt;
  bit          saw_done;
  logic [CL-1:0] packed_bits;
`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] crc_at_done;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < CL; i++) exp_bits[i] = words[i / WW][WW - 1 - (i % WW)];
    for (int i = 0; i < CL; i++) packed_bits[CL - 1 - i] = exp_bits[i];
    check("model_bitstream", 32'(packed_bits), 32'h000A53CF);
`ifdef CONFIG_LOADER_CRC_EN
    check("model_crc_zero_byte", 32'(crc_of(32'h0, 8)), 32'h0000E1F0);
`endif

    // Reset state, with word_valid high to show it is ignored.
    word_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_enable", {31'b0, config_enable}, 32'd0);
    check("reset_ready", {31'b0, word_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(posedge clock); #1;
    nreset = 1'b1;
    word_valid = 1'b0;
    check_on = 1'b1;
    @(negedge clock);
    check("idle_ready", {31'b0, word_ready}, 32'd0);

    // Back-to-back stream.
    @(posedge clock); #1;
    do_load(-1, 0, -1, -1, -1, en_cnt, gap_cnt, saw_done);
    check("stream_done", {31'b0, saw_done}, 32'd1);
    check("stream_bits", 32'(en_cnt), 32'd20);
    check("stream_gap", 32'(gap_cnt), 32'd0);
    check("stream_chain", 32'(chain), 32'h000A53CF);
`ifdef CONFIG_LOADER_CRC_EN
    check("stream_crc", 32'(crc), 32'(crc_of(32'h000A53CF, 20)));
    crc_at_done = crc;
`endif
    word_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("done_hold", {31'b0, done}, 32'd1);
    end
    check("done_chain_hold", 32'(chain), 32'h000A53CF);
`ifdef CONFIG_LOADER_CRC_EN
    check("crc_frozen", 32'(crc), 32'(crc_at_done));
`endif
    word_valid = 1'b0;
    chain = '0;

    // Starved stream from DONE: word 1 withheld for 12 cycles -> 5 stalled cycles.
    @(posedge clock); #1;
    do_load(1, 12, -1, -1, -1, en_cnt, gap_cnt, saw_done);
    check("starve_done", {31'b0, saw_done}, 32'd1);
    check("starve_bits", 32'(en_cnt), 32'd20);
    check("starve_gap", 32'(gap_cnt), 32'd5);
    check("starve_chain", 32'(chain), 32'h000A53CF);

    // Abort after 10 bits (abort lands while the 11th bit is on the chain).
    chain = '0;
    @(posedge clock); #1;
    do_load(-1, 0, 10, -1, -1, en_cnt, gap_cnt, saw_done);
    check("abort_bits", 32'(en_cnt), 32'd11);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_enable", {31'b0, config_enable}, 32'd0);

    // Full load with a start pulse while busy.
    @(posedge clock); #1;
    do_load(-1, 0, -1, 3, -1, en_cnt, gap_cnt, saw_done);
    check("restart_done", {31'b0, saw_done}, 32'd1);
    check("restart_bits", 32'(en_cnt), 32'd20);
    check("restart_chain", 32'(chain), 32'h000A53CF);
`ifdef CONFIG_LOADER_CRC_EN
    check("restart_crc", 32'(crc), 32'(crc_of(32'h000A53CF, 20)));
`endif

    // Reset mid-SHIFT.
    @(posedge clock); #1;
    do_load(-1, 0, -1, -1, 5, en_cnt, gap_cnt, saw_done);
    check("midrst_bits", 32'(en_cnt), 32'd6);
    check("midrst_enable", {31'b0, config_enable}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_ready", {31'b0, word_ready}, 32'd0);
    @(posedge clock); #1;
    nreset = 1'b1;

    // Recovery load after reset.
    chain = '0;
    @(posedge clock); #1;
    do_load(-1, 0, -1, -1, -1, en_cnt, gap_cnt, saw_done);
    check("recover_done", {31'b0, saw_done}, 32'd1);
    check("recover_bits", 32'(en_cnt), 32'd20);
    check("recover_chain", 32'(chain), 32'h000A53CF);

    @(posedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
